// File: rtl/mcu_avalon_pkg.sv
// Shared types and bit positions for the MCU Avalon-MM master.
// The FSM state encoding, status bit layout and control bit layout live here.
package mcu_avalon_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_READ_CMD  = 2'd2,
    S_READ_WAIT = 2'd3
  } state_t;

  localparam int ST_BUSY     = 0;
  localparam int ST_TIMEOUT  = 1;
  localparam int ST_AUTO_INC = 2;
  localparam int ST_RD_VALID = 3;
  localparam int ST_OVERRUN  = 4;

  localparam int CTRL_RD   = 0;
  localparam int CTRL_AINC = 1;
  localparam int CTRL_CLR  = 2;

endpackage

// File: rtl/av_timeout_counter.sv
// Cycle counter that flags a stuck bus transaction.
// Ties expired low when TIMEOUT_CYCLES is 0.
module av_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = clk ^ rst_n ^ clear ^ enable;
    assign expired   = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && !expired) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/mcu_avalon_master.sv
// Avalon-MM master bridging the MCU register file to the fabric.
// Single reads/writes, optional post-increment, bus timeout, MCU stall.
module mcu_avalon_master
  import mcu_avalon_pkg::*;
#(
  parameter int ADDR_WIDTH        = 16,
  parameter int DATA_WIDTH        = 16,
  parameter int USE_READDATAVALID = 0,
  parameter int ADDR_STRIDE       = 2,
  parameter int TIMEOUT_CYCLES    = 1023
) (
  input  logic                  sysclk,
  input  logic                  sysreset_n,
  input  logic [DATA_WIDTH-1:0] r_load_data,
  input  logic                  load_address,
  input  logic                  load_writedata,
  input  logic                  load_ctrl,
  output logic [ADDR_WIDTH-1:0] r_address,
  output logic [DATA_WIDTH-1:0] r_writedata,
  output logic [DATA_WIDTH-1:0] r_readdata,
  output logic [DATA_WIDTH-1:0] r_status,
  output logic                  mcu_wait,
  output logic [ADDR_WIDTH-1:0] av_address,
  output logic                  av_write,
  output logic                  av_read,
  output logic [DATA_WIDTH-1:0] av_writedata,
  input  logic [DATA_WIDTH-1:0] av_readdata,
  input  logic                  av_waitrequest,
  input  logic                  av_readdatavalid
);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic auto_inc_q, auto_inc_d;
  logic timeout_q, timeout_d;
  logic overrun_q, overrun_d;
  logic rd_valid_q, rd_valid_d;

  logic idle;
  logic complete;
  logic expired;
  logic any_load;
  logic rd_req;

  assign idle     = (state_q == S_IDLE);
  assign any_load = load_address | load_writedata | load_ctrl;
  assign rd_req   = load_ctrl & r_load_data[CTRL_RD];

  av_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (sysclk),
    .rst_n  (sysreset_n),
    .clear  (state_d != state_q),
    .enable (!idle),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    auto_inc_d = auto_inc_q;
    timeout_d  = timeout_q;
    overrun_d  = overrun_q;
    rd_valid_d = rd_valid_q;
    av_write   = 1'b0;
    av_read    = 1'b0;
    complete   = 1'b0;

    if (idle) begin
      if (load_address) begin
        addr_d = r_load_data[ADDR_WIDTH-1:0];
      end
      if (load_ctrl) begin
        auto_inc_d = r_load_data[CTRL_AINC];
        if (r_load_data[CTRL_CLR]) begin
          timeout_d = 1'b0;
          overrun_d = 1'b0;
        end
      end
      // A simultaneous read request loses to the write.
      if (load_writedata) begin
        wdata_d = r_load_data;
        state_d = S_WRITE;
        if (rd_req) begin
          overrun_d = 1'b1;
        end
      end else if (rd_req) begin
        state_d    = S_READ_CMD;
        rd_valid_d = 1'b0;
      end
    end else if (any_load) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_WRITE: begin
        if (expired) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          av_write = 1'b1;
          if (!av_waitrequest) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_READ_CMD: begin
        if (expired) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          rdata_d   = '1;
        end else begin
          av_read = 1'b1;
          if (!av_waitrequest) begin
            if (USE_READDATAVALID != 0) begin
              state_d = S_READ_WAIT;
            end else begin
              complete   = 1'b1;
              state_d    = S_IDLE;
              rdata_d    = av_readdata;
              rd_valid_d = 1'b1;
            end
          end
        end
      end
      S_READ_WAIT: begin
        if (expired) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          rdata_d   = '1;
        end else if (av_readdatavalid) begin
          complete   = 1'b1;
          state_d    = S_IDLE;
          rdata_d    = av_readdata;
          rd_valid_d = 1'b1;
        end
      end
    endcase

    if (complete && auto_inc_q) begin
      addr_d = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      auto_inc_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      auto_inc_q <= auto_inc_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign mcu_wait     = !idle && !complete;
  assign r_address    = addr_q;
  assign av_address   = addr_q;
  assign r_writedata  = wdata_q;
  assign av_writedata = wdata_q;
  assign r_readdata   = rdata_q;

  always_comb begin
    r_status              = '0;
    r_status[ST_BUSY]     = !idle;
    r_status[ST_TIMEOUT]  = timeout_q;
    r_status[ST_AUTO_INC] = auto_inc_q;
    r_status[ST_RD_VALID] = rd_valid_q;
    r_status[ST_OVERRUN]  = overrun_q;
  end

endmodule

// File: tb/tb_mcu_avalon_master.sv
// Bench for mcu_avalon_master: dut0 fixed-latency reads, dut1 readdatavalid.
// Register-level model per instance, directed steps then random traffic.
module tb_mcu_avalon_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0] ld_data[2];
  logic        ld_addr[2];
  logic        ld_wr[2];
  logic        ld_ctrl[2];
  logic [15:0] av_rd[2];
  logic        av_wreq[2];
  logic        av_rdv[2];

  logic [15:0] r_addr[2];
  logic [15:0] r_wd[2];
  logic [15:0] r_rd[2];
  logic [15:0] r_st[2];
  logic [15:0] av_addr[2];
  logic [15:0] av_wd[2];
  logic        wt[2];
  logic        av_w[2];
  logic        av_r[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mcu_avalon_master #(
      .ADDR_WIDTH       (16),
      .DATA_WIDTH       (16),
      .USE_READDATAVALID(g),
      .ADDR_STRIDE      (2),
      .TIMEOUT_CYCLES   (8)
    ) dut (
      .sysclk          (clk),
      .sysreset_n      (rst_n),
      .r_load_data     (ld_data[g]),
      .load_address    (ld_addr[g]),
      .load_writedata  (ld_wr[g]),
      .load_ctrl       (ld_ctrl[g]),
      .r_address       (r_addr[g]),
      .r_writedata     (r_wd[g]),
      .r_readdata      (r_rd[g]),
      .r_status        (r_st[g]),
      .mcu_wait        (wt[g]),
      .av_address      (av_addr[g]),
      .av_write        (av_w[g]),
      .av_read         (av_r[g]),
      .av_writedata    (av_wd[g]),
      .av_readdata     (av_rd[g]),
      .av_waitrequest  (av_wreq[g]),
      .av_readdatavalid(av_rdv[g])
    );
  end

  logic [15:0] m_addr[2];
  logic [15:0] m_wd[2];
  logic [15:0] m_rd[2];
  logic        m_ai[2];
  logic        m_to[2];
  logic        m_ov[2];
  logic        m_rv[2];

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, int k, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d obs=%h exp=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_status(int k);
    return {11'b0, m_ov[k], m_rv[k], m_ai[k], m_to[k], 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(int k);
    m_addr[k] = '0;
    m_wd[k]   = '0;
    m_rd[k]   = '0;
    m_ai[k]   = 1'b0;
    m_to[k]   = 1'b0;
    m_ov[k]   = 1'b0;
    m_rv[k]   = 1'b0;
  endtask

  task automatic check_regs(int k);
    chk("r_address", k, r_addr[k], m_addr[k]);
    chk("r_writedata", k, r_wd[k], m_wd[k]);
    chk("r_readdata", k, r_rd[k], m_rd[k]);
    chk("r_status", k, r_st[k], m_status(k));
    chk("idle_wait", k, 16'(wt[k]), 16'd0);
    chk("idle_rw", k, {14'b0, av_w[k], av_r[k]}, 16'd0);
  endtask

  task automatic do_load_addr(int k, logic [15:0] a);
    ld_data[k] = a;
    ld_addr[k] = 1'b1;
    tick();
    ld_addr[k] = 1'b0;
    m_addr[k] = a;
  endtask

  task automatic do_ctrl(int k, logic [2:0] v);
    ld_data[k] = {13'b0, v[2:1], 1'b0};
    ld_ctrl[k] = 1'b1;
    tick();
    ld_ctrl[k] = 1'b0;
    m_ai[k] = v[1];
    if (v[2]) begin
      m_to[k] = 1'b0;
      m_ov[k] = 1'b0;
    end
  endtask

  task automatic do_write(int k, logic [15:0] d, int wn, bit inj, bit both);
    logic [15:0] d2;
    d2 = d;
    if (both) d2[0] = 1'b1;
    ld_data[k] = d2;
    ld_wr[k] = 1'b1;
    ld_ctrl[k] = both;
    tick();
    ld_wr[k] = 1'b0;
    ld_ctrl[k] = 1'b0;
    m_wd[k] = d2;
    if (both) begin
      m_ai[k] = d2[1];
      if (d2[2]) begin
        m_to[k] = 1'b0;
        m_ov[k] = 1'b0;
      end
      m_ov[k] = 1'b1;
    end
    for (int c = 0; c <= wn; c++) begin
      av_wreq[k] = (c < wn);
      if (inj && c == 0) begin
        ld_wr[k] = 1'b1;
        ld_addr[k] = 1'b1;
        ld_data[k] = ~d2;
      end else begin
        ld_wr[k] = 1'b0;
        ld_addr[k] = 1'b0;
      end
      @(negedge clk);
      chk("av_write", k, 16'(av_w[k]), 16'd1);
      chk("wr_wait", k, 16'(wt[k]), 16'(c < wn));
      chk("wr_addr", k, av_addr[k], m_addr[k]);
      chk("wr_data", k, av_wd[k], d2);
      tick();
    end
    ld_wr[k] = 1'b0;
    ld_addr[k] = 1'b0;
    av_wreq[k] = 1'b0;
    if (inj) m_ov[k] = 1'b1;
    if (m_ai[k]) m_addr[k] = m_addr[k] + 16'd2;
    check_regs(k);
  endtask

  task automatic do_read(int k, logic [15:0] d, int wn, int lat);
    ld_data[k] = {13'b0, 1'b0, m_ai[k], 1'b1};
    ld_ctrl[k] = 1'b1;
    tick();
    ld_ctrl[k] = 1'b0;
    m_rv[k] = 1'b0;
    for (int c = 0; c <= wn; c++) begin
      av_wreq[k] = (c < wn);
      av_rd[k] = (c == wn && k == 0) ? d : 16'($urandom);
      @(negedge clk);
      chk("av_read", k, 16'(av_r[k]), 16'd1);
      chk("rd_wait", k, 16'(wt[k]), 16'((k == 1) || (c < wn)));
      chk("rd_addr", k, av_addr[k], m_addr[k]);
      tick();
    end
    av_wreq[k] = 1'b0;
    if (k == 1) begin
      for (int j = 0; j <= lat; j++) begin
        av_rdv[k] = (j == lat);
        av_rd[k] = (j == lat) ? d : 16'($urandom);
        @(negedge clk);
        chk("rdv_read", k, 16'(av_r[k]), 16'd0);
        chk("rdv_wait", k, 16'(wt[k]), 16'(j < lat));
        tick();
      end
      av_rdv[k] = 1'b0;
    end
    m_rd[k] = d;
    m_rv[k] = 1'b1;
    if (m_ai[k]) m_addr[k] = m_addr[k] + 16'd2;
    check_regs(k);
  endtask

  task automatic do_timeout(int k);
    ld_data[k] = {13'b0, 1'b0, m_ai[k], 1'b1};
    ld_ctrl[k] = 1'b1;
    tick();
    ld_ctrl[k] = 1'b0;
    av_wreq[k] = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      chk("tmo_read", k, 16'(av_r[k]), 16'(c < 8));
      tick();
    end
    av_wreq[k] = 1'b0;
    m_rd[k] = 16'hFFFF;
    m_to[k] = 1'b1;
    m_rv[k] = 1'b0;
    check_regs(k);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ld_data[k] = '0;
      ld_addr[k] = 1'b0;
      ld_wr[k]   = 1'b0;
      ld_ctrl[k] = 1'b0;
      av_rd[k]   = '0;
      av_wreq[k] = 1'b0;
      av_rdv[k]  = 1'b0;
      model_reset(k);
    end
    repeat (2) tick();
    check_regs(0);
    check_regs(1);
    rst_n = 1'b1;
    tick();

    do_load_addr(0, 16'h0010);
    do_write(0, 16'hBEEF, 3, 1'b0, 1'b0);
    do_load_addr(0, 16'h0020);
    do_read(0, 16'h1234, 0, 0);
    do_load_addr(1, 16'h0020);
    do_read(1, 16'hA5A5, 0, 5);

    av_rdv[1] = 1'b1;
    av_rd[1] = ~m_rd[1];
    tick();
    av_rdv[1] = 1'b0;
    check_regs(1);

    do_ctrl(0, 3'b010);
    do_load_addr(0, 16'hFFFE);
    do_write(0, 16'h1111, 1, 1'b0, 1'b0);
    do_write(0, 16'h2222, 0, 1'b0, 1'b0);
    chk("wrap_addr", 0, r_addr[0], 16'h0002);
    do_ctrl(0, 3'b000);

    do_timeout(0);
    do_timeout(1);
    do_ctrl(0, 3'b100);
    do_ctrl(1, 3'b100);
    check_regs(0);
    check_regs(1);

    do_write(0, 16'h5A5A, 3, 1'b1, 1'b0);
    do_write(1, 16'hC3C3, 2, 1'b0, 1'b1);
    do_ctrl(0, 3'b100);
    do_ctrl(1, 3'b100);
    check_regs(0);
    check_regs(1);

    for (int i = 0; i < 80; i++) begin
      int k;
      int op;
      k = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 5));
      case (op)
        0: do_load_addr(k, 16'($urandom));
        1: do_ctrl(k, 3'($urandom_range(0, 7)));
        2, 3: do_write(k, 16'($urandom), int'($urandom_range(0, 6)),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        default: do_read(k, 16'($urandom), int'($urandom_range(0, 6)),
                         int'($urandom_range(0, 6)));
      endcase
    end

    ld_data[0] = 16'h0001;
    ld_ctrl[0] = 1'b1;
    tick();
    ld_ctrl[0] = 1'b0;
    av_wreq[0] = 1'b1;
    tick();
    chk("pre_rst_read", 0, 16'(av_r[0]), 16'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      chk("rst_read", k, 16'(av_r[k]), 16'd0);
      chk("rst_wait", k, 16'(wt[k]), 16'd0);
      chk("rst_status", k, r_st[k], 16'd0);
    end
    tick();
    av_wreq[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    check_regs(0);
    check_regs(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
